// File: rtl/ti_bus_capture_pkg.sv
// Shared types and constants for the TI host write-capture path.
package ti_bus_capture_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    QUAL      = 2'd2,
    ACTIVE    = 2'd3
  } state_e;

endpackage

// File: rtl/ti_bus_write_capture_sync_2ff.sv
// Two-flop synchronizer for asynchronous TI bus inputs; reset value chosen per signal.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // NOTE: sequential state uses non-blocking assignments so s2 takes the old s1 value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/ti_bus_write_capture.sv
// Captures TI host writes into the clk domain with a valid/ready holding register.
// Optional deglitch qualification is enabled by defining TI_BUS_CAPTURE_DEGLITCH_EN.
module ti_bus_write_capture
  import ti_bus_capture_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ti_we_n,
  input  logic               ti_sel,
  input  logic [WIDTH-1:0]   ti_d,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun,
  input  logic               ovr_clr,
  output logic [COUNT_W-1:0] wr_count
);

  localparam logic [1:0] SETTLE_DONE = 2'(SYNC_STAGES);

  logic             we_n_s2;
  logic             sel_s2;
  logic [WIDTH-1:0] d_s2;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_we (
    .clk, .rst_n, .d_i(ti_we_n), .q_o(we_n_s2)
  );

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_sel (
    .clk, .rst_n, .d_i(ti_sel), .q_o(sel_s2)
  );

  sync_2ff #(.WIDTH(WIDTH), .RESET_VAL('0)) u_sync_d (
    .clk, .rst_n, .d_i(ti_d), .q_o(d_s2)
  );

  state_e             state_q, state_d;
  logic [1:0]         settle_q, settle_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;
  logic [COUNT_W-1:0] wr_count_q, wr_count_d;
  logic               qual;
  logic               capture;
  logic               load;
  logic               drop;

  assign qual = !we_n_s2 && sel_s2;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    capture  = 1'b0;

    // The synchronizer still shows its reset value for SYNC_STAGES cycles after
    // reset; a strobe held low across reset must not look like a fresh high.
    if (settle_q != SETTLE_DONE) settle_d = settle_q + 2'd1;

    case (state_q)
      WAIT_HIGH: if (settle_q == SETTLE_DONE && we_n_s2) state_d = IDLE;
      IDLE: begin
        if (qual) begin
`ifdef TI_BUS_CAPTURE_DEGLITCH_EN
          state_d = QUAL;
`else
          state_d = ACTIVE;
          capture = 1'b1;
`endif
        end
      end
      QUAL: begin
`ifdef TI_BUS_CAPTURE_DEGLITCH_EN
        if (qual) begin
          state_d = ACTIVE;
          capture = 1'b1;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      ACTIVE:  if (we_n_s2) state_d = IDLE;
      default: state_d = WAIT_HIGH;
    endcase

    load = capture && (!out_valid_q || out_ready);
    drop = capture && !load;

    out_data_d  = load ? d_s2 : out_data_q;
    wr_count_d  = load ? wr_count_q + COUNT_W'(1) : wr_count_q;

    if (load)                          out_valid_d = 1'b1;
    else if (out_valid_q && out_ready) out_valid_d = 1'b0;
    else                               out_valid_d = out_valid_q;

    // A new overrun in the same cycle as a clear keeps the flag set.
    if (drop)         overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
    else              overrun_d = overrun_q;
  end

  // NOTE: the holding register is reset too, so a byte in flight is discarded on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_HIGH;
      settle_q    <= 2'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_ti_bus_write_capture.sv
// Directed, table-driven bench for ti_bus_write_capture (honours TI_BUS_CAPTURE_DEGLITCH_EN).
module tb_ti_bus_write_capture;

`ifdef TI_BUS_CAPTURE_DEGLITCH_EN
  localparam int  LAT     = 4;
  localparam bit  DEGLITCH = 1'b1;
`else
  localparam int  LAT     = 3;
  localparam bit  DEGLITCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ti_we_n;
  logic       ti_sel;
  logic [7:0] ti_d;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       ovr_clr;
  logic [7:0] wr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ti_bus_write_capture #(.WIDTH(8), .COUNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ti_we_n   (ti_we_n),
    .ti_sel    (ti_sel),
    .ti_d      (ti_d),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .wr_count  (wr_count)
  );

  typedef struct {
    logic [7:0] d;
    logic       sel;
    int         low;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ovr;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Data settles 3 cycles before the strobe falls; strobe low for 'low' cycles.
  task automatic write(input logic [7:0] d, input logic sel, input int low, input int high);
    ti_d   = d;
    ti_sel = sel;
    repeat (3) @(negedge clk);
    ti_we_n = 1'b0;
    repeat (low) @(negedge clk);
    ti_we_n = 1'b1;
    repeat (high) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ti_we_n = 1'b1; ti_sel = 1'b0; ti_d = 8'h00;
    out_ready = 1'b0; ovr_clr = 1'b0;

    vecs[0] = '{8'h3C, 1'b1, 20, 1'b1, 1'b0, 8'h3C, 1'b0, 8'd2};  // held strobe, one capture
    vecs[1] = '{8'h11, 1'b1, 3,  1'b0, 1'b1, 8'h11, 1'b0, 8'd3};
    vecs[2] = '{8'h22, 1'b1, 3,  1'b0, 1'b1, 8'h11, 1'b1, 8'd3};  // overrun drop
    vecs[3] = '{8'h44, 1'b0, 3,  1'b0, 1'b1, 8'h11, 1'b1, 8'd3};  // not selected
    vecs[4] = '{8'h66, 1'b1, 3,  1'b1, 1'b0, 8'h66, 1'b1, 8'd4};  // overrun sticky

    repeat (3) @(negedge clk);
    check("rst data",  32'(out_data),  32'h0);
    check("rst valid", 32'(out_valid), 32'h0);
    check("rst ovr",   32'(overrun),   32'h0);
    check("rst cnt",   32'(wr_count),  32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Latency of a single write.
    ti_d = 8'hA5; ti_sel = 1'b1;
    repeat (3) @(negedge clk);
    ti_we_n = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1 check("lat early valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1 check("lat valid", 32'(out_valid), 32'h1);
    check("lat data", 32'(out_data), 32'hA5);
    check("lat cnt",  32'(wr_count), 32'h1);
    @(negedge clk);
    ti_we_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      out_ready = vecs[i].ready;
      write(vecs[i].d, vecs[i].sel, vecs[i].low, 5);
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d data", i),  32'(out_data),  32'(vecs[i].exp_data));
      check($sformatf("vec%0d ovr", i),   32'(overrun),   32'(vecs[i].exp_ovr));
      check($sformatf("vec%0d cnt", i),   32'(wr_count),  32'(vecs[i].exp_cnt));
    end
    out_ready = 1'b0;

    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    @(negedge clk);
    check("ovr clr", 32'(overrun), 32'h0);

    // Simultaneous accept and capture.
    write(8'h11, 1'b1, 3, 5);
    check("pre sim valid", 32'(out_valid), 32'h1);
    check("pre sim cnt",   32'(wr_count),  32'h5);
    ti_d = 8'h22;
    repeat (3) @(negedge clk);
    ti_we_n = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("sim data", 32'(out_data),  32'h22);
    check("sim valid",   32'(out_valid), 32'h1);
    check("sim ovr",     32'(overrun),   32'h0);
    check("sim cnt",     32'(wr_count),  32'h6);
    @(negedge clk);
    out_ready = 1'b0;
    ti_we_n   = 1'b1;
    repeat (5) @(negedge clk);
    check("sim hold valid", 32'(out_valid), 32'h1);

    // One-cycle strobe: captured only without deglitch.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    write(8'h5A, 1'b1, 1, 6);
    check("glitch valid", 32'(out_valid), DEGLITCH ? 32'h0 : 32'h1);
    check("glitch cnt",   32'(wr_count),  DEGLITCH ? 32'h6 : 32'h7);
    check("glitch data",  32'(out_data),  DEGLITCH ? 32'h22 : 32'h5A);

    // Reset in the middle of a held strobe, released with strobe still low.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ti_d = 8'h77;
    repeat (3) @(negedge clk);
    ti_we_n = 1'b0;
    repeat (6) @(negedge clk);
    check("pre rst data", 32'(out_data), 32'h77);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid rst data",  32'(out_data),  32'h0);
    check("mid rst valid", 32'(out_valid), 32'h0);
    check("mid rst cnt",   32'(wr_count),  32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post rst valid", 32'(out_valid), 32'h0);
    check("post rst cnt",   32'(wr_count),  32'h0);
    ti_we_n = 1'b1;
    repeat (5) @(negedge clk);
    write(8'h5A, 1'b1, 3, 5);
    check("new strobe valid", 32'(out_valid), 32'h1);
    check("new strobe data",  32'(out_data),  32'h5A);
    check("new strobe cnt",   32'(wr_count),  32'h1);

    // Counter wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 254; i++) write(8'(i), 1'b1, 3, 4);
    check("cnt max", 32'(wr_count), 32'hFF);
    write(8'hEE, 1'b1, 3, 4);
    check("cnt wrap",   32'(wr_count), 32'h0);
    check("wrap ovr",   32'(overrun),  32'h0);
    check("wrap data",  32'(out_data), 32'hEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
